hex_scan_driver: RTL and testbench

- Multi-digit, time-multiplexed 7-segment hex display driver for the calculator front panel; next generation of the single-digit hex decoder.
- Captures an N_DIGITS-nibble value on a load strobe and scans one digit per refresh slot onto shared active-low segment lines with per-digit enables.
- Adds error dash display, whole-display blanking and leading-zero suppression; sits between the calculator result register and the board display pins.

---
 rtl/hex_disp_pkg.sv | 34 +++
 rtl/hex_seg_decode.sv | 11 +
 rtl/hex_scan_driver.sv | 112 +++++++++++
 tb/tb_hex_scan_driver.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared types and segment constants for the hex display drivers.
// Segment vectors are ordered g..a (bit 6 = g, bit 0 = a).
package hex_disp_pkg;

   typedef logic [6:0] seg7_t;

   localparam seg7_t SEG_BLANK = 7'h7F;
   localparam seg7_t SEG_DASH  = 7'b0111111;

   // Active-high segment pattern for one hex digit
   function automatic seg7_t hex_pattern(input logic [3:0] nib);
      seg7_t p;
      case (nib)
         4'h0: p = 7'b0111111;
         4'h1: p = 7'b0000110;
         4'h2: p = 7'b1011011;
         4'h3: p = 7'b1001111;
         4'h4: p = 7'b1100110;
         4'h5: p = 7'b1101101;
         4'h6: p = 7'b1111101;
         4'h7: p = 7'b0000111;
         4'h8: p = 7'b1111111;
         4'h9: p = 7'b1101111;
         4'hA: p = 7'b1110111;
         4'hB: p = 7'b1111100;
         4'hC: p = 7'b0111001;
         4'hD: p = 7'b1011110;
         4'hE: p = 7'b1111001;
         default: p = 7'b1110001;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-low 7-segment decoder.
module hex_seg_decode
   import hex_disp_pkg::*;
(
   input  logic [3:0] nibble,
   output seg7_t      seg_n
);

   assign seg_n = ~hex_pattern(nibble);

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed multi-digit hex display driver with dash, blank and LZ suppression.
// Optional macro HEX_SCAN_BLINK_EN makes the error dashes blink via a frame counter.
module hex_scan_driver
   import hex_disp_pkg::*;
#(
   parameter int N_DIGITS      = 4,
   parameter int REFRESH_DIV   = 50000,
   parameter int AN_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] value,
   input  logic                  error,
   input  logic                  off_bit,
   input  logic                  lz_suppress,
   output seg7_t                 seg_n,
   output logic [N_DIGITS-1:0]   an
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [N_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;

   logic [PW-1:0]         presc;
   logic [IW-1:0]         idx;
   logic [IW-1:0]         idx_next;
   logic [4*N_DIGITS-1:0] shadow;
   logic                  tick;
   logic                  wrap;
   logic [3:0]            nibble;
   logic                  lz_blank;
   logic [N_DIGITS-1:0]   onehot;
   logic [N_DIGITS-1:0]   an_val;
   logic                  zero_above;
   logic                  blink_off;
   seg7_t                 dec_seg;

   assign tick     = (presc == PW'(REFRESH_DIV - 1));
   assign wrap     = (idx == IW'(N_DIGITS - 1));
   assign idx_next = wrap ? '0 : idx + 1'b1;
   assign an_val   = (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;

   // idx points at the digit driven on the next tick, so scan starts at digit 0
   always_comb begin
      nibble     = '0;
      onehot     = '0;
      lz_blank   = 1'b0;
      zero_above = 1'b1;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         zero_above = zero_above && (shadow[4*k +: 4] == 4'h0);
         if (idx == IW'(k)) begin
            nibble    = shadow[4*k +: 4];
            onehot[k] = 1'b1;
            lz_blank  = (k != 0) && zero_above;
         end
      end
   end

   hex_seg_decode u_decode (
      .nibble (nibble),
      .seg_n  (dec_seg)
   );

`ifdef HEX_SCAN_BLINK_EN
   logic [7:0] frame;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame <= '0;
      end else if (tick && wrap) begin
         frame <= frame + 8'd1;
      end
   end

   assign blink_off = frame[7];
`else
   assign blink_off = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc  <= '0;
         idx    <= '0;
         shadow <= '0;
         seg_n  <= SEG_BLANK;
         an     <= AN_OFF;
      end else begin
         if (load) begin
            shadow <= value;
         end
         if (tick) begin
            presc <= '0;
            idx   <= idx_next;
            // outputs read the pre-load shadow when load and tick coincide
            if (error) begin
               seg_n <= blink_off ? SEG_BLANK : SEG_DASH;
               an    <= an_val;
            end else if (off_bit) begin
               seg_n <= SEG_BLANK;
               an    <= AN_OFF;
            end else begin
               seg_n <= (lz_suppress && lz_blank) ? SEG_BLANK : dec_seg;
               an    <= an_val;
            end
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed self-checking bench for hex_scan_driver (N_DIGITS=4, REFRESH_DIV=4).
module tb_hex_scan_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic        error = 1'b0;
   logic        off_bit = 1'b0;
   logic        lz_suppress = 1'b0;
   logic [6:0]  seg_n;
   logic [3:0]  an;

   int pass_cnt = 0;
   int total_cnt = 0;

   hex_scan_driver #(
      .N_DIGITS      (4),
      .REFRESH_DIV   (4),
      .AN_ACTIVE_LOW (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .value       (value),
      .error       (error),
      .off_bit     (off_bit),
      .lz_suppress (lz_suppress),
      .seg_n       (seg_n),
      .an          (an)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      load = 1'b0;
      error = 1'b0;
      off_bit = 1'b0;
      lz_suppress = 1'b0;
      value = '0;
      step(2);
      rst = 1'b0;
   endtask

   // load on the first edge after reset, return sampled just after the first tick
   task automatic load_then_first_tick(input logic [15:0] v);
      value = v;
      load = 1'b1;
      step(1);
      load = 1'b0;
      step(3);
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++;
      if (seg_n !== 7'h7F || an !== 4'hF)
         $display("FAIL reset_init seg_n=%h an=%h want 7f f", seg_n, an);
      else pass_cnt++;
      load_then_first_tick(16'h12AF);
      step(5);
      rst = 1'b1;
      #1;
      total_cnt++;
      if (seg_n !== 7'h7F || an !== 4'hF)
         $display("FAIL reset_async seg_n=%h an=%h want 7f f", seg_n, an);
      else pass_cnt++;
      step(1);
      rst = 1'b0;
      step(3);
      total_cnt++;
      if (seg_n !== 7'h7F || an !== 4'hF)
         $display("FAIL reset_pre_tick seg_n=%h an=%h want 7f f", seg_n, an);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (seg_n !== 7'h40 || an !== 4'hE)
         $display("FAIL reset_first_tick seg_n=%h an=%h want 40 e", seg_n, an);
      else pass_cnt++;
   endtask

   task automatic test_scan();
      logic [6:0] exp_seg [5] = '{7'h0E, 7'h08, 7'h24, 7'h79, 7'h0E};
      logic [3:0] exp_an  [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
      do_reset();
      load_then_first_tick(16'h12AF);
      for (int d = 0; d < 5; d++) begin
         if (d > 0) step(4);
         total_cnt++;
         if (seg_n !== exp_seg[d] || an !== exp_an[d])
            $display("FAIL scan_slot%0d seg_n=%h an=%h want %h %h", d, seg_n, an, exp_seg[d], exp_an[d]);
         else pass_cnt++;
      end
      step(3);
      total_cnt++;
      if (seg_n !== 7'h0E || an !== 4'hE)
         $display("FAIL scan_hold seg_n=%h an=%h want 0e e", seg_n, an);
      else pass_cnt++;
   endtask

   task automatic test_priority();
      logic [3:0] exp_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
      do_reset();
      error = 1'b1;
      off_bit = 1'b1;
      load_then_first_tick(16'h12AF);
      for (int d = 0; d < 4; d++) begin
         if (d > 0) step(4);
         total_cnt++;
         if (seg_n !== 7'b0111111 || an !== exp_an[d])
            $display("FAIL prio_dash%0d seg_n=%h an=%h want 3f %h", d, seg_n, an, exp_an[d]);
         else pass_cnt++;
      end
      error = 1'b0;
      for (int d = 0; d < 2; d++) begin
         step(4);
         total_cnt++;
         if (seg_n !== 7'h7F || an !== 4'hF)
            $display("FAIL prio_off%0d seg_n=%h an=%h want 7f f", d, seg_n, an);
         else pass_cnt++;
      end
      off_bit = 1'b0;
      step(4);
      total_cnt++;
      if (seg_n !== 7'h24 || an !== 4'hB)
         $display("FAIL prio_resume seg_n=%h an=%h want 24 b", seg_n, an);
      else pass_cnt++;
   endtask

   task automatic test_lz();
      logic [6:0] exp_a [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
      logic [6:0] exp_b [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
      logic [3:0] exp_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
      do_reset();
      lz_suppress = 1'b1;
      load_then_first_tick(16'h0050);
      for (int d = 0; d < 4; d++) begin
         if (d > 0) step(4);
         total_cnt++;
         if (seg_n !== exp_a[d] || an !== exp_an[d])
            $display("FAIL lz_0050_d%0d seg_n=%h an=%h want %h %h", d, seg_n, an, exp_a[d], exp_an[d]);
         else pass_cnt++;
      end
      do_reset();
      lz_suppress = 1'b1;
      load_then_first_tick(16'h0000);
      for (int d = 0; d < 4; d++) begin
         if (d > 0) step(4);
         total_cnt++;
         if (seg_n !== exp_b[d] || an !== exp_an[d])
            $display("FAIL lz_zero_d%0d seg_n=%h an=%h want %h %h", d, seg_n, an, exp_b[d], exp_an[d]);
         else pass_cnt++;
      end
      lz_suppress = 1'b0;
      step(4);
      total_cnt++;
      if (seg_n !== 7'h40 || an !== 4'hE)
         $display("FAIL lz_off seg_n=%h an=%h want 40 e", seg_n, an);
      else pass_cnt++;
   endtask

   task automatic test_load_collision();
      do_reset();
      value = 16'h2222;
      load = 1'b1;
      step(1);
      load = 1'b0;
      step(2);
      value = 16'h1111;
      load = 1'b1;
      step(1);
      load = 1'b0;
      total_cnt++;
      if (seg_n !== 7'h24 || an !== 4'hE)
         $display("FAIL collide_old seg_n=%h an=%h want 24 e", seg_n, an);
      else pass_cnt++;
      step(4);
      total_cnt++;
      if (seg_n !== 7'h79 || an !== 4'hD)
         $display("FAIL collide_new seg_n=%h an=%h want 79 d", seg_n, an);
      else pass_cnt++;
   endtask

   task automatic test_blink();
      logic [3:0] exp_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
      int dash_frames = 0;
      int blank_frames = 0;
      int bad = 0;
      int exp_dash;
      int exp_blank;
      int first_blank = -1;
      int exp_first_blank;
      int nd;
      int nb;
`ifdef HEX_SCAN_BLINK_EN
      exp_dash = 128;
      exp_blank = 128;
      exp_first_blank = 128;
`else
      exp_dash = 256;
      exp_blank = 0;
      exp_first_blank = -1;
`endif
      do_reset();
      error = 1'b1;
      step(3);
      for (int f = 0; f < 256; f++) begin
         nd = 0;
         nb = 0;
         for (int d = 0; d < 4; d++) begin
            step(1);
            if (an !== exp_an[d]) bad++;
            if (seg_n === 7'b0111111) nd++;
            else if (seg_n === 7'h7F) nb++;
            else bad++;
            step(3);
         end
         if (nd == 4) dash_frames++;
         else if (nb == 4) begin
            blank_frames++;
            if (first_blank < 0) first_blank = f;
         end
         else bad++;
      end
      error = 1'b0;
      total_cnt++;
      if (dash_frames !== exp_dash)
         $display("FAIL blink_dash_frames got %0d want %0d", dash_frames, exp_dash);
      else pass_cnt++;
      total_cnt++;
      if (blank_frames !== exp_blank)
         $display("FAIL blink_blank_frames got %0d want %0d", blank_frames, exp_blank);
      else pass_cnt++;
      total_cnt++;
      if (first_blank !== exp_first_blank)
         $display("FAIL blink_first_blank got %0d want %0d", first_blank, exp_first_blank);
      else pass_cnt++;
      total_cnt++;
      if (bad !== 0)
         $display("FAIL blink_bad_samples got %0d want 0", bad);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_scan();
      test_priority();
      test_lz();
      test_load_collision();
      test_blink();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
